alu_result_fifo: RTL and testbench

//  Parametrised result buffer between ALU and write-back/observation logic.

---
 rtl/alu_result_fifo.sv | 111 +++++++++++
 tb/tb_alu_result_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through result buffer between the ALU and
// write-back/observation logic. It holds up to DEPTH words, keeps a copy of the
// most recently consumed word in last_out, and supports a synchronous flush.
//
// Handshake: a word moves across an interface on a rising CLK edge where both
// valid and ready are high (push = in_valid & in_ready, pop = out_valid &
// out_ready). in_ready depends only on registered fullness and out_valid only
// on registered emptiness, so neither ready nor valid combinationally follows
// the opposite side of the buffer.
module alu_result_fifo #(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           last_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] last_out_q, last_out_d;
   logic             push;
   logic             pop;
   logic             mem_we;

   // Pointers wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   // Status flags and handshake outputs, all from registered occupancy.
   always_comb begin
      full      = (count_q == DEPTH_C);
      empty     = (count_q == '0);
      in_ready  = !full;
      out_valid = !empty;
      out_data  = mem_q[rd_ptr_q];
      count     = count_q;
      last_out  = last_out_q;
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      mem_we    = push & !flush;
   end

   // Next-state: flush wins over push/pop; last_out captures the popped word.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      last_out_d = last_out_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            last_out_d = out_data;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_out_q <= RESET_VALUE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         last_out_q <= last_out_d;
      end
   end

   // Storage array: no reset, contents are only meaningful while counted.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed bench for alu_result_fifo. Instance a is the
// DEPTH=4 / WIDTH=32 buffer, instance b the DEPTH=3 / WIDTH=8 buffer.
module tb_alu_result_fifo;

   logic clk;
   logic rst;

   // DEPTH=4 instance signals
   logic        a_flush, a_in_valid, a_out_ready;
   logic [31:0] a_in_data;
   logic        a_in_ready, a_out_valid, a_full, a_empty;
   logic [31:0] a_out_data, a_last_out;
   logic [2:0]  a_count;

   // DEPTH=3 instance signals
   logic        b_flush, b_in_valid, b_out_ready;
   logic [7:0]  b_in_data;
   logic        b_in_ready, b_out_valid, b_full, b_empty;
   logic [7:0]  b_out_data, b_last_out;
   logic [1:0]  b_count;

   int n_checks;
   int n_fail;

   logic [7:0] exp_q[$];

   alu_result_fifo #(.WIDTH(32), .DEPTH(4), .RESET_VALUE(32'h0)) dut_a (
      .CLK(clk), .RST(rst), .flush(a_flush),
      .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
      .last_out(a_last_out), .count(a_count), .full(a_full), .empty(a_empty)
   );

   alu_result_fifo #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h0)) dut_b (
      .CLK(clk), .RST(rst), .flush(b_flush),
      .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
      .last_out(b_last_out), .count(b_count), .full(b_full), .empty(b_empty)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      int unsigned e_cnt;
      logic [31:0] e_data;
      logic [31:0] e_last;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic fl, input logic iv, input logic [31:0] id, input logic ordy);
      a_flush     = fl;
      a_in_valid  = iv;
      a_in_data   = id;
      a_out_ready = ordy;
   endtask

   initial begin
      logic [31:0] w;
      int          npush_b;
      logic        iv, ordy, push, pop;
      logic [7:0]  d;

      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      drive_a(1'b0, 1'b0, 32'h0, 1'b0);
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h0; b_out_ready = 1'b0;

      // fill, overfill attempt, drain, pop-on-empty
      vecs[0] = '{1'b0, 1'b1, 32'h11, 1'b0, 1, 32'h11, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 32'h22, 1'b0, 2, 32'h11, 32'h0};
      vecs[2] = '{1'b0, 1'b1, 32'h33, 1'b0, 3, 32'h11, 32'h0};
      vecs[3] = '{1'b0, 1'b1, 32'h44, 1'b0, 4, 32'h11, 32'h0};
      vecs[4] = '{1'b0, 1'b1, 32'h55, 1'b0, 4, 32'h11, 32'h0};
      vecs[5] = '{1'b0, 1'b1, 32'h55, 1'b1, 3, 32'h22, 32'h11};
      vecs[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 2, 32'h33, 32'h22};
      vecs[7] = '{1'b0, 1'b0, 32'h0,  1'b1, 1, 32'h44, 32'h33};
      vecs[8] = '{1'b0, 1'b0, 32'h0,  1'b1, 0, 32'h0,  32'h44};
      vecs[9] = '{1'b0, 1'b0, 32'h0,  1'b1, 0, 32'h0,  32'h44};

      step();
      step();
      rst = 1'b0;
      #1;

      // reset state
      check("rst_count", 32'(a_count), 32'd0);
      check("rst_empty", 32'(a_empty), 32'd1);
      check("rst_full", 32'(a_full), 32'd0);
      check("rst_in_ready", 32'(a_in_ready), 32'd1);
      check("rst_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_last_out", a_last_out, 32'h0);

      // table-driven fill/drain on the DEPTH=4 instance
      for (int i = 0; i < 10; i++) begin
         drive_a(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
         step();
         check($sformatf("vec%0d_count", i), 32'(a_count), vecs[i].e_cnt);
         check($sformatf("vec%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].e_cnt != 0));
         check($sformatf("vec%0d_full", i), 32'(a_full), 32'(vecs[i].e_cnt == 4));
         check($sformatf("vec%0d_empty", i), 32'(a_empty), 32'(vecs[i].e_cnt == 0));
         check($sformatf("vec%0d_in_ready", i), 32'(a_in_ready), 32'(vecs[i].e_cnt != 4));
         check($sformatf("vec%0d_last_out", i), a_last_out, vecs[i].e_last);
         if (vecs[i].e_cnt != 0)
            check($sformatf("vec%0d_out_data", i), a_out_data, vecs[i].e_data);
      end

      // simultaneous push/pop at count=2, pointers wrap several times
      drive_a(1'b0, 1'b1, 32'hA0, 1'b0);
      step();
      drive_a(1'b0, 1'b1, 32'hA1, 1'b0);
      step();
      check("sim_start_count", 32'(a_count), 32'd2);
      for (int i = 0; i < 10; i++) begin
         w = 32'hA2 + 32'(i);
         drive_a(1'b0, 1'b1, w, 1'b1);
         check($sformatf("sim%0d_out_data", i), a_out_data, 32'hA0 + 32'(i));
         step();
         check($sformatf("sim%0d_count", i), 32'(a_count), 32'd2);
      end
      check("sim_last_out", a_last_out, 32'hA9);
      check("sim_next_data", a_out_data, 32'hAA);

      // flush: set up count=3 with last_out=0x22
      drive_a(1'b0, 1'b0, 32'h0, 1'b1);
      step();
      step();
      check("pre_flush_empty", 32'(a_empty), 32'd1);
      drive_a(1'b0, 1'b1, 32'h22, 1'b0);
      step();
      drive_a(1'b0, 1'b0, 32'h0, 1'b1);
      step();
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b0, 1'b1, 32'h31 + 32'(i), 1'b0);
         step();
      end
      check("pre_flush_count", 32'(a_count), 32'd3);
      check("pre_flush_last", a_last_out, 32'h22);
      drive_a(1'b1, 1'b1, 32'h99, 1'b1);
      step();
      check("flush_count", 32'(a_count), 32'd0);
      check("flush_empty", 32'(a_empty), 32'd1);
      check("flush_out_valid", 32'(a_out_valid), 32'd0);
      check("flush_last_out", a_last_out, 32'h22);
      drive_a(1'b0, 1'b1, 32'h77, 1'b0);
      step();
      check("post_flush_count", 32'(a_count), 32'd1);
      check("post_flush_data", a_out_data, 32'h77);
      drive_a(1'b0, 1'b0, 32'h0, 1'b1);
      step();
      check("post_flush_last", a_last_out, 32'h77);
      check("post_flush_empty", 32'(a_empty), 32'd1);

      // asynchronous reset mid-cycle with 3 words queued
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b0, 1'b1, 32'hC0 + 32'(i), 1'b0);
         step();
      end
      drive_a(1'b0, 1'b0, 32'h0, 1'b0);
      check("pre_rst_count", 32'(a_count), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_count", 32'(a_count), 32'd0);
      check("async_rst_empty", 32'(a_empty), 32'd1);
      check("async_rst_out_valid", 32'(a_out_valid), 32'd0);
      check("async_rst_last_out", a_last_out, 32'h0);
      step();
      rst = 1'b0;
      step();

      // DEPTH=3 random traffic against a queue model
      exp_q.delete();
      npush_b = 0;
      for (int i = 0; i < 40; i++) begin
         iv   = ($urandom_range(0, 99) < 65);
         ordy = ($urandom_range(0, 99) < 45);
         d    = 8'($urandom_range(0, 255));
         b_in_valid  = iv;
         b_out_ready = ordy;
         b_in_data   = d;
         check($sformatf("b%0d_out_valid", i), 32'(b_out_valid), 32'(exp_q.size() != 0));
         check($sformatf("b%0d_in_ready", i), 32'(b_in_ready), 32'(exp_q.size() < 3));
         if (exp_q.size() != 0)
            check($sformatf("b%0d_out_data", i), 32'(b_out_data), 32'(exp_q[0]));
         push = iv && (exp_q.size() < 3);
         pop  = ordy && (exp_q.size() != 0);
         if (pop) void'(exp_q.pop_front());
         if (push) begin
            exp_q.push_back(d);
            npush_b++;
         end
         step();
         check($sformatf("b%0d_count", i), 32'(b_count), 32'(exp_q.size()));
         check($sformatf("b%0d_count_le3", i), 32'(b_count <= 2'd3 && b_count != 2'd3 || exp_q.size() == 3), 32'd1);
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b0;
      check("b_wrap_exercised", 32'(npush_b > 3), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
